// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache single-word requests onto one RAM port, dcache first.
// Define ARB_FAIR_EN to cap consecutive dcache grants while the icache is waiting.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 7) begin : g_streak_range
        $error("mem_arbiter: MAX_DSTREAK must lie in 1..7");
    end

    state_t state_r;
    state_t next_state_s;
    logic   d_req_s;
    logic   access_s;
    logic   fair_turn_s;

    assign d_req_s  = dREN | dWEN;
    assign access_s = (ramstate == RAM_ACCESS);

    // Load data is a pure pass-through; the wait lines qualify it.
    assign iload = ramload;
    assign dload = ramload;

`ifdef ARB_FAIR_EN
    logic [2:0] streak_r;
    logic       i_done_s;
    logic       d_done_s;

    assign i_done_s    = (state_r == IGRANT) & iREN & access_s;
    assign d_done_s    = (state_r == DGRANT) & d_req_s & access_s;
    assign fair_turn_s = iREN & (streak_r >= 3'(MAX_DSTREAK));

    // Dcache completions in a row while the icache waits; saturates at 7.
    always_ff @(posedge CLK) begin
        if (RST) begin
            streak_r <= 3'd0;
        end else if (i_done_s) begin
            streak_r <= 3'd0;
        end else if (d_done_s && iREN) begin
            streak_r <= (streak_r == 3'd7) ? 3'd7 : streak_r + 3'd1;
        end else if (d_done_s) begin
            streak_r <= 3'd0;
        end else begin
            streak_r <= streak_r;
        end
    end
`else
    assign fair_turn_s = 1'b0;
`endif

    // Grant state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration and release; a withdrawn request releases the port immediately.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_req_s && !fair_turn_s) begin
                    next_state_s = DGRANT;
                end else if (iREN) begin
                    next_state_s = IGRANT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IGRANT: begin
                if (!iREN || access_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = IGRANT;
                end
            end
            DGRANT: begin
                if (!d_req_s || access_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DGRANT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // RAM strobes and wait lines; reset and withdrawal both look like IDLE.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {ADDR_W{1'b0}};
        ramstore = {DATA_W{1'b0}};
        iwait    = 1'b1;
        dwait    = 1'b1;
        if (RST) begin
            ramREN = 1'b0;
            ramWEN = 1'b0;
        end else begin
            case (state_r)
                IGRANT: begin
                    if (iREN) begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr;
                        iwait   = ~access_s;
                    end else begin
                        ramREN = 1'b0;
                    end
                end
                DGRANT: begin
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                        ramaddr  = daddr;
                        dwait    = ~access_s;
                    end else if (dREN) begin
                        ramREN  = 1'b1;
                        ramaddr = daddr;
                        dwait   = ~access_s;
                    end else begin
                        ramREN = 1'b0;
                    end
                end
                default: begin
                    ramREN = 1'b0;
                    ramWEN = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level owner model.
module tb_mem_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int MAX_DSTREAK = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              iREN, dREN, dWEN;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [DATA_W-1:0] dstore, ramload;
    logic [1:0]        ramstate;
    logic              iwait, dwait, ramREN, ramWEN;
    logic [DATA_W-1:0] iload, dload, ramstore;
    logic [ADDR_W-1:0] ramaddr;

    int n_pass  = 0;
    int n_total = 0;

    // model: who owns the port (0 none, 1 icache, 2 dcache) and dcache win streak
    int owner_m  = 0;
    int streak_m = 0;

    logic              e_ren, e_wen, e_iw, e_dw;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_store;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(MAX_DSTREAK)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit icache_turn();
`ifdef ARB_FAIR_EN
        return iREN && (streak_m >= MAX_DSTREAK);
`else
        return 1'b0;
`endif
    endfunction

    // Owner model advanced at each active edge.
    always @(posedge CLK) begin
        if (RST) begin
            owner_m  <= 0;
            streak_m <= 0;
        end else if (owner_m == 0) begin
            if ((dREN || dWEN) && !icache_turn()) owner_m <= 2;
            else if (iREN) owner_m <= 1;
        end else if (owner_m == 1) begin
            if (!iREN) owner_m <= 0;
            else if (ramstate == 2'd2) begin
                owner_m  <= 0;
                streak_m <= 0;
            end
        end else begin
            if (!(dREN || dWEN)) owner_m <= 0;
            else if (ramstate == 2'd2) begin
                owner_m  <= 0;
                streak_m <= iREN ? ((streak_m < 7) ? streak_m + 1 : 7) : 0;
            end
        end
    end

    // Compare every output against the model on the falling edge.
    initial forever begin
        @(negedge CLK);
        e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr = 32'h0; e_store = 32'h0;
        if (!RST && owner_m == 1 && iREN) begin
            e_ren  = 1'b1;
            e_addr = iaddr;
            e_iw   = (ramstate != 2'd2);
        end else if (!RST && owner_m == 2 && (dREN || dWEN)) begin
            e_addr = daddr;
            e_dw   = (ramstate != 2'd2);
            if (dWEN) begin
                e_wen   = 1'b1;
                e_store = dstore;
            end else begin
                e_ren = 1'b1;
            end
        end
        check("ramREN", 32'(ramREN), 32'(e_ren));
        check("ramWEN", 32'(ramWEN), 32'(e_wen));
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("iwait", 32'(iwait), 32'(e_iw));
        check("dwait", 32'(dwait), 32'(e_dw));
        check("iload", iload, ramload);
        check("dload", dload, ramload);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic idle_in();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    endtask

    task automatic settle();
        idle_in();
        step();
        step();
    endtask

    logic [1:0] st_seq [4];
    int d_before, d_after, first_i;

    initial begin
        st_seq = '{2'd1, 2'd3, 2'd1, 2'd2};
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = 2'd0;
        step(); step();
        RST = 1'b0;
        at_neg();
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        settle();

        // icache miss, ACCESS three cycles after the strobe
        iREN = 1'b1; iaddr = 32'h0000_0040;
        step();
        at_neg();
        check("imiss_ren", 32'(ramREN), 32'd1);
        check("imiss_addr", ramaddr, 32'h40);
        for (int k = 0; k < 2; k++) begin
            step(); ramstate = 2'd1;
            at_neg();
            check("imiss_hold", 32'(iwait), 32'd1);
        end
        step(); ramstate = 2'd2; ramload = 32'h8C01_0004;
        at_neg();
        check("imiss_iwait", 32'(iwait), 32'd0);
        check("imiss_iload", iload, 32'h8C01_0004);
        step(); iREN = 1'b0; ramstate = 2'd0;
        at_neg();
        check("imiss_after", 32'(iwait), 32'd1);
        check("imiss_idle", 32'(ramREN), 32'd0);
        settle();

        // simultaneous requests: dcache write first, then icache read
        iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        step(); ramstate = 2'd2;
        at_neg();
        check("sim_wen", 32'(ramWEN), 32'd1);
        check("sim_ren0", 32'(ramREN), 32'd0);
        check("sim_store", ramstore, 32'hDEAD_BEEF);
        check("sim_daddr", ramaddr, 32'h200);
        check("sim_dwait", 32'(dwait), 32'd0);
        check("sim_iwait", 32'(iwait), 32'd1);
        step(); dWEN = 1'b0; ramstate = 2'd0;
        step(); ramstate = 2'd2;
        at_neg();
        check("sim_iren", 32'(ramREN), 32'd1);
        check("sim_iaddr", ramaddr, 32'h100);
        check("sim_ipulse", 32'(iwait), 32'd0);
        settle();

        // BUSY, ERROR, BUSY, ACCESS
        dREN = 1'b1; daddr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            step(); ramstate = st_seq[k];
            at_neg();
            check("err_ren", 32'(ramREN), 32'd1);
            check("err_dwait", 32'(dwait), (k == 3) ? 32'd0 : 32'd1);
        end
        settle();

        // icache withdrawal while BUSY
        iREN = 1'b1; iaddr = 32'h44;
        step(); ramstate = 2'd1;
        at_neg();
        check("wd_ren", 32'(ramREN), 32'd1);
        step(); iREN = 1'b0;
        at_neg();
        check("wd_drop", 32'(ramREN), 32'd0);
        check("wd_iwait", 32'(iwait), 32'd1);
        check("wd_addr", ramaddr, 32'h0);
        settle();

        // reset in the middle of a dcache grant
        dREN = 1'b1; daddr = 32'h90;
        step(); ramstate = 2'd1;
        at_neg();
        check("mrst_ren", 32'(ramREN), 32'd1);
        step(); RST = 1'b1; ramstate = 2'd2;
        at_neg();
        check("mrst_dwait", 32'(dwait), 32'd1);
        step(); RST = 1'b0;
        at_neg();
        check("mrst_idle", 32'(ramREN), 32'd0);
        check("mrst_dwait2", 32'(dwait), 32'd1);
        settle();

        // both caches hammering with single-cycle ACCESS
        RST = 1'b1; step(); RST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h304; daddr = 32'h300; ramstate = 2'd2;
        d_before = 0; d_after = 0; first_i = -1;
        for (int k = 0; k < 24; k++) begin
            at_neg();
            if (iwait == 1'b0 && first_i < 0) first_i = d_before;
            if (dwait == 1'b0) begin
                if (first_i < 0) d_before++;
                else d_after++;
            end
            step();
        end
`ifdef ARB_FAIR_EN
        check("fair_streak", 32'(first_i), 32'd4);
        check("fair_resume", 32'(d_after > 0), 32'd1);
`else
        check("prio_starve", 32'(first_i), 32'hFFFF_FFFF);
        check("prio_dcount", 32'(d_before), 32'd12);
`endif
        settle();

        // randomised traffic
        for (int k = 0; k < 700; k++) begin
            step();
            RST = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0) iREN = ~iREN;
            if ($urandom_range(0, 5) == 0) dREN = ~dREN;
            if ($urandom_range(0, 9) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 3) == 0) iaddr = $urandom;
            if ($urandom_range(0, 3) == 0) daddr = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
